// File: rtl/clock_ctrl.sv
// 24-hour time-of-day controller: 1 Hz prescaler, five-mode set/run FSM,
// alarm compare with ring latch and one-minute auto-off.
module clock_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_en,
  input  logic       ack,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [5:0] al_min,
  output logic [4:0] al_hour,
  output logic [2:0] mode,
  output logic       tick,
  output logic       ring
);

  localparam int            PW    = $clog2(CLK_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    AL_HR   = 3'd3,
    AL_MIN  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec, r_min, r_al_min;
  logic [4:0]    r_hour, r_al_hour;
  logic          r_ring;

  logic       w_running, w_tick, w_inc;
  logic       w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic [5:0] w_nsec, w_nmin;
  logic [4:0] w_nhour;
  logic       w_match, w_auto_off;

  assign w_running = (r_state == RUN) || (r_state == AL_HR) || (r_state == AL_MIN);
  assign w_tick    = w_running && (r_presc == P_MAX);
  // mode_btn wins over a coincident inc_btn
  assign w_inc     = inc_btn && !mode_btn;

  assign w_sec_wrap = (r_sec == 6'd59);
  assign w_min_wrap = (r_min == 6'd59);
  assign w_hr_wrap  = (r_hour == 5'd23);
  assign w_nsec     = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
  assign w_nmin     = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_min + 6'd1) : r_min;
  assign w_nhour    = (w_sec_wrap && w_min_wrap) ? (w_hr_wrap ? 5'd0 : r_hour + 5'd1) : r_hour;

  assign w_match    = w_tick && (w_nsec == 6'd0) && (w_nmin == r_al_min) && (w_nhour == r_al_hour);
  assign w_auto_off = w_tick && (r_min == r_al_min) && (w_nmin != r_min);

  always_comb begin
    w_state_nxt = r_state;
    if (mode_btn) begin
      case (r_state)
        RUN:     w_state_nxt = SET_HR;
        SET_HR:  w_state_nxt = SET_MIN;
        SET_MIN: w_state_nxt = AL_HR;
        AL_HR:   w_state_nxt = AL_MIN;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_presc <= '0;
    else if (!w_running || w_tick)  r_presc <= '0;
    else                            r_presc <= r_presc + PW'(1);
  end

  // Ticks only occur in running states, so they never collide with the set-mode writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
    end else begin
      if (w_tick) begin
        r_sec  <= w_nsec;
        r_min  <= w_nmin;
        r_hour <= w_nhour;
      end
      if (r_state == SET_HR && w_inc)  r_hour <= w_hr_wrap  ? 5'd0 : r_hour + 5'd1;
      if (r_state == SET_MIN && w_inc) r_min  <= w_min_wrap ? 6'd0 : r_min + 6'd1;
      if (r_state == SET_MIN && mode_btn) r_sec <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_al_hour <= '0;
      r_al_min  <= '0;
    end else begin
      if (r_state == AL_HR && w_inc)  r_al_hour <= (r_al_hour == 5'd23) ? 5'd0 : r_al_hour + 5'd1;
      if (r_state == AL_MIN && w_inc) r_al_min  <= (r_al_min == 6'd59)  ? 6'd0 : r_al_min + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_ring <= 1'b0;
    else if (!alarm_en)          r_ring <= 1'b0;
    else if (w_match)            r_ring <= 1'b1;
    else if (ack || w_auto_off)  r_ring <= 1'b0;
  end

  assign sec     = r_sec;
  assign min     = r_min;
  assign hour    = r_hour;
  assign al_min  = r_al_min;
  assign al_hour = r_al_hour;
  assign mode    = r_state;
  assign tick    = w_tick;
  assign ring    = r_ring;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: vector table, directed corner sequences
// and random stimulus against a seconds-of-day reference model.
module tb_clock_ctrl;
  localparam int DIV = 4;

  logic       clk = 0, rst = 0;
  logic       mode_btn = 0, inc_btn = 0, alarm_en = 0, ack = 0;
  logic [5:0] sec, min, al_min;
  logic [4:0] hour, al_hour;
  logic [2:0] mode;
  logic       tick, ring;

  clock_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .alarm_en(alarm_en), .ack(ack), .sec(sec), .min(min), .hour(hour),
    .al_min(al_min), .al_hour(al_hour), .mode(mode), .tick(tick), .ring(ring)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic last_tick;

  // model: time as seconds of day, phase within the current second
  int m_t, m_mode, m_ph, m_alh, m_alm;
  bit m_ring;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_running();
    return (m_mode == 0) || (m_mode == 3) || (m_mode == 4);
  endfunction

  function automatic bit m_tick();
    return m_running() && (m_ph == DIV - 1);
  endfunction

  task automatic m_step(input bit mb, input bit ib, input bit ak, input bit en);
    bit tk;
    bit run;
    int nt, h, mi;
    tk  = m_tick();
    run = m_running();
    nt  = (m_t + 1) % 86400;
    h   = m_t / 3600;
    mi  = (m_t / 60) % 60;
    if (!en) m_ring = 0;
    else if (tk && nt == m_alh * 3600 + m_alm * 60) m_ring = 1;
    else if (ak) m_ring = 0;
    else if (tk && mi == m_alm && (nt / 60) % 60 != m_alm) m_ring = 0;
    if (tk) m_t = nt;
    if (mb) begin
      if (m_mode == 2) m_t = m_t - m_t % 60;
      m_mode = (m_mode + 1) % 5;
    end else if (ib) begin
      case (m_mode)
        1: m_t = ((h + 1) % 24) * 3600 + m_t % 3600;
        2: m_t = m_t - mi * 60 + ((mi + 1) % 60) * 60;
        3: m_alh = (m_alh + 1) % 24;
        4: m_alm = (m_alm + 1) % 60;
        default: ;
      endcase
    end
    m_ph = (run && m_ph != DIV - 1) ? m_ph + 1 : 0;
  endtask

  task automatic chk_all();
    chk("sec",     sec,     m_t % 60);
    chk("min",     min,     (m_t / 60) % 60);
    chk("hour",    hour,    m_t / 3600);
    chk("al_hour", al_hour, m_alh);
    chk("al_min",  al_min,  m_alm);
    chk("mode",    mode,    m_mode);
    chk("ring",    ring,    m_ring);
  endtask

  task automatic step(input bit mb, input bit ib, input bit ak);
    @(negedge clk);
    mode_btn = mb; inc_btn = ib; ack = ak;
    last_tick = tick;
    chk("tick", tick, m_tick());
    m_step(mb, ib, ak, alarm_en);
    @(posedge clk); #1;
    chk_all();
  endtask

  // called at posedge+1; reset pulse sits entirely between two edges
  task automatic do_reset();
    mode_btn = 0; inc_btn = 0; ack = 0;
    #1 rst = 0;
    #1;
    chk("rst_sec", sec, 0);   chk("rst_min", min, 0);   chk("rst_hour", hour, 0);
    chk("rst_alh", al_hour, 0); chk("rst_alm", al_min, 0);
    chk("rst_mode", mode, 0); chk("rst_ring", ring, 0); chk("rst_tick", tick, 0);
    m_t = 0; m_mode = 0; m_ph = 0; m_alh = 0; m_alm = 0; m_ring = 0;
    #1 rst = 1;
  endtask

  task automatic run_until(input int target, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      step(0, 0, 0);
      if (m_t == target) ok = 1;
    end
    if (!ok) chk("timeout", 0, 1);
  endtask

  task automatic alarm_0001();
    do_reset();
    alarm_en = 1;
    repeat (4) step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
  endtask

  typedef struct {
    bit mb, ib;
    int e_mode, e_hour, e_min, e_alh, e_alm;
  } vec_t;
  vec_t vecs[11];

  initial begin
    bit ok, seen;
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 2, 0, 0, 0};
    vecs[3]  = '{1, 1, 2, 2, 0, 0, 0};
    vecs[4]  = '{0, 1, 2, 2, 1, 0, 0};
    vecs[5]  = '{1, 0, 3, 2, 1, 0, 0};
    vecs[6]  = '{0, 1, 3, 2, 1, 1, 0};
    vecs[7]  = '{1, 0, 4, 2, 1, 1, 0};
    vecs[8]  = '{0, 1, 4, 2, 1, 1, 1};
    vecs[9]  = '{1, 0, 0, 2, 1, 1, 1};
    vecs[10] = '{0, 1, 0, 2, 1, 1, 1};

    @(posedge clk); #1;

    // reset then run
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0);
      chk("tick_cycle", last_tick, (i % 4) == 0);
      if (i == 4) chk("sec_after_4", sec, 1);
    end
    repeat (232) step(0, 0, 0);
    chk("min_after_240", min, 1);
    chk("sec_after_240", sec, 0);

    // vector table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].mb, vecs[i].ib, 0);
      chk("vec_mode", mode, vecs[i].e_mode);
      chk("vec_hour", hour, vecs[i].e_hour);
      chk("vec_min",  min,  vecs[i].e_min);
      chk("vec_alh",  al_hour, vecs[i].e_alh);
      chk("vec_alm",  al_min,  vecs[i].e_alm);
    end

    // 23:59 rollover
    do_reset();
    step(1, 0, 0);
    repeat (23) step(0, 1, 0);
    step(1, 0, 0);
    repeat (59) step(0, 1, 0);
    step(1, 0, 0);
    chk("roll_pre_hour", hour, 23); chk("roll_pre_min", min, 59);
    chk("roll_pre_sec", sec, 0);    chk("roll_pre_mode", mode, 3);
    repeat (60 * DIV) step(0, 0, 0);
    chk("roll_hour", hour, 0); chk("roll_min", min, 0); chk("roll_sec", sec, 0);

    // freeze and wrap in SET_HR
    do_reset();
    step(1, 0, 0);
    seen = 0;
    repeat (100) begin
      step(0, 0, 0);
      if (last_tick) seen = 1;
    end
    chk("freeze_tick", seen, 0);
    chk("freeze_sec", sec, 0);
    repeat (23) step(0, 1, 0);
    chk("sethr_23", hour, 23);
    step(0, 1, 0);
    chk("sethr_wrap", hour, 0);
    chk("sethr_min", min, 0);

    // alarm 00:01, no ack
    alarm_0001();
    run_until(59, 400, ok);
    chk("ring_before", ring, 0);
    run_until(60, 10, ok);
    chk("ring_on_match", ring, 1);
    chk("match_min", min, 1);
    run_until(119, 400, ok);
    chk("ring_held", ring, 1);
    run_until(120, 10, ok);
    chk("ring_autooff", ring, 0);

    // alarm with ack mid-minute
    alarm_0001();
    run_until(80, 600, ok);
    chk("ring_mid", ring, 1);
    step(0, 0, 1);
    chk("ring_ack", ring, 0);

    // ack coincident with match tick, then alarm_en drop
    alarm_0001();
    run_until(59, 400, ok);
    for (int i = 0; i < 8 && !m_tick(); i++) step(0, 0, 0);
    step(0, 0, 1);
    chk("set_beats_ack", ring, 1);
    alarm_en = 0;
    step(0, 0, 0);
    chk("en_off", ring, 0);
    alarm_en = 1;

    // collision mode+inc in SET_HR
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    chk("coll_mode", mode, 2);
    chk("coll_hour", hour, 0);

    // async reset at 12:34:56 with ring high
    do_reset();
    alarm_en = 1;
    step(1, 0, 0);
    repeat (12) step(0, 1, 0);
    step(1, 0, 0);
    repeat (33) step(0, 1, 0);
    step(1, 0, 0);
    repeat (12) step(0, 1, 0);
    step(1, 0, 0);
    repeat (34) step(0, 1, 0);
    step(1, 0, 0);
    run_until(12 * 3600 + 34 * 60 + 56, 1000, ok);
    chk("pre_rst_ring", ring, 1);
    chk("pre_rst_sec", sec, 56);
    do_reset();

    // random stimulus
    alarm_en = 1;
    repeat (800) begin
      if ($urandom_range(0, 49) == 0) alarm_en = ~alarm_en;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
